// File: rtl/seg_display_scan.sv
// Eight-digit multiplexed hex display scanner for CPU observation words.
// The word is latched at each frame start so a frame never shows mixed data.
module seg_display_scan #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  display_op,
    input  logic [9:0]  ram_display_addr,
    input  logic [31:0] reg_out,
    input  logic [31:0] pc,
    input  logic [31:0] ram_data,
    input  logic [31:0] total_cycles,
    input  logic [31:0] jump_cycles,
    input  logic [31:0] branch_cycles,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    localparam logic [2:0] OP_REG   = 3'b000;
    localparam logic [2:0] OP_PC    = 3'b001;
    localparam logic [2:0] OP_RAM   = 3'b010;
    localparam logic [2:0] OP_ADDR  = 3'b011;
    localparam logic [2:0] OP_TOTAL = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_BR    = 3'b110;
    localparam logic [2:0] OP_BLANK = 3'b111;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [2:0]    op_q, op_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic [31:0]   sel_word;
    logic [3:0]    nib;
    logic [6:0]    hex;

    assign tick = (presc_q == PMAX);

    always_comb begin
        sel_word = 32'h0;
        unique case (display_op)
            OP_REG:   sel_word = reg_out;
            OP_PC:    sel_word = pc;
            OP_RAM:   sel_word = ram_data;
            OP_ADDR:  sel_word = {22'b0, ram_display_addr};
            OP_TOTAL: sel_word = total_cycles;
            OP_JUMP:  sel_word = jump_cycles;
            OP_BR:    sel_word = branch_cycles;
            OP_BLANK: sel_word = 32'h0;
            default:  sel_word = 32'h0;
        endcase
    end

    always_comb begin
        hex = 7'h7F;
        unique case (nib)
            4'h0: hex = 7'b1000000;
            4'h1: hex = 7'b1111001;
            4'h2: hex = 7'b0100100;
            4'h3: hex = 7'b0110000;
            4'h4: hex = 7'b0011001;
            4'h5: hex = 7'b0010010;
            4'h6: hex = 7'b0000010;
            4'h7: hex = 7'b1111000;
            4'h8: hex = 7'b0000000;
            4'h9: hex = 7'b0010000;
            4'hA: hex = 7'b0001000;
            4'hB: hex = 7'b0000011;
            4'hC: hex = 7'b1000110;
            4'hD: hex = 7'b0100001;
            4'hE: hex = 7'b0000110;
            4'hF: hex = 7'b0001110;
            default: hex = 7'h7F;
        endcase
    end

    // Next-state values feed the digit decode so the new frame's first
    // digit already shows the freshly latched word.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        op_d    = op_q;
        an_d    = an_q;
        seg_d   = seg_q;
        nib     = 4'(snap_q >> {idx_q, 2'b00});
        if (tick) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                op_d   = display_op;
                snap_d = sel_word;
            end
            nib = 4'(snap_d >> {idx_d, 2'b00});
            if (op_d == OP_BLANK) begin
                an_d  = 8'hFF;
                seg_d = 7'h7F;
            end else begin
                an_d  = ~(8'b1 << idx_d);
                seg_d = hex;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= 3'd7;
            snap_q  <= 32'h0;
            op_q    <= 3'b000;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            op_q    <= op_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with a short scan divider.
// Each scenario task drives stimulus and checks outputs inline.
module tb_seg_display_scan;

    logic        clk;
    logic        rst_n;
    logic [2:0]  display_op;
    logic [9:0]  ram_display_addr;
    logic [31:0] reg_out;
    logic [31:0] pc;
    logic [31:0] ram_data;
    logic [31:0] total_cycles;
    logic [31:0] jump_cycles;
    logic [31:0] branch_cycles;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total;
    int bad;

    seg_display_scan #(.SCAN_DIV(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .display_op       (display_op),
        .ram_display_addr (ram_display_addr),
        .reg_out          (reg_out),
        .pc               (pc),
        .ram_data         (ram_data),
        .total_cycles     (total_cycles),
        .jump_cycles      (jump_cycles),
        .branch_cycles    (branch_cycles),
        .an               (an),
        .seg              (seg),
        .dp               (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] hx(input logic [3:0] n);
        case (n)
            4'h0: hx = 7'b1000000;
            4'h1: hx = 7'b1111001;
            4'h2: hx = 7'b0100100;
            4'h3: hx = 7'b0110000;
            4'h4: hx = 7'b0011001;
            4'h5: hx = 7'b0010010;
            4'h6: hx = 7'b0000010;
            4'h7: hx = 7'b1111000;
            4'h8: hx = 7'b0000000;
            4'h9: hx = 7'b0010000;
            4'hA: hx = 7'b0001000;
            4'hB: hx = 7'b0000011;
            4'hC: hx = 7'b1000110;
            4'hD: hx = 7'b0100001;
            4'hE: hx = 7'b0000110;
            default: hx = 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] nib_of(input logic [31:0] w, input int d);
        logic [31:0] s;
        s = w >> (4 * d);
        nib_of = s[3:0];
    endfunction

    function automatic logic [7:0] an_of(input int d);
        logic [7:0] one;
        one = 8'b1;
        an_of = ~(one << d);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic next_digit();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        display_op = 3'b001;
        pc = 32'h89AB_CDEF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (an !== 8'hFF) begin
            bad++;
            $display("FAIL reset_an got=%h want=ff", an);
        end
        total++;
        if (seg !== 7'h7F) begin
            bad++;
            $display("FAIL reset_seg got=%b want=1111111", seg);
        end
        total++;
        if (dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_dp got=%b want=1", dp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (an !== 8'hFF) begin
            bad++;
            $display("FAIL startup_early got=%h want=ff", an);
        end
        @(posedge clk);
        #1;
        total++;
        if (an !== 8'hFE) begin
            bad++;
            $display("FAIL startup_first got=%h want=fe", an);
        end
        for (int k = 1; k < 8; k++) begin
            next_digit();
            total++;
            if (an !== an_of(k)) begin
                bad++;
                $display("FAIL step_an%0d got=%h want=%h", k, an, an_of(k));
            end
        end
        next_digit();
        total++;
        if (an !== 8'hFE) begin
            bad++;
            $display("FAIL wrap_an got=%h want=fe", an);
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp_seg [8];
        exp_seg[0] = 7'b0001110;
        exp_seg[1] = 7'b0000110;
        exp_seg[2] = 7'b0100001;
        exp_seg[3] = 7'b1000110;
        exp_seg[4] = 7'b0000011;
        exp_seg[5] = 7'b0001000;
        exp_seg[6] = 7'b0010000;
        exp_seg[7] = 7'b0000000;
        display_op = 3'b001;
        pc = 32'h89AB_CDEF;
        do_reset();
        for (int d = 0; d < 8; d++) begin
            next_digit();
            total++;
            if (an !== an_of(d) || seg !== exp_seg[d]) begin
                bad++;
                $display("FAIL hex_d%0d got=%h/%b want=%h/%b",
                         d, an, seg, an_of(d), exp_seg[d]);
            end
        end
    endtask

    task automatic test_frame_latch();
        logic [31:0] tc;
        tc = 32'h7654_3210;
        display_op = 3'b000;
        reg_out = 32'h1111_1111;
        total_cycles = tc;
        do_reset();
        for (int d = 0; d < 4; d++) next_digit();
        reg_out = 32'h2222_2222;
        display_op = 3'b100;
        for (int d = 4; d < 8; d++) begin
            next_digit();
            total++;
            if (an !== an_of(d) || seg !== 7'b1111001) begin
                bad++;
                $display("FAIL latch_hold_d%0d got=%h/%b want=%h/1111001",
                         d, an, seg, an_of(d));
            end
        end
        for (int d = 0; d < 8; d++) begin
            next_digit();
            total++;
            if (an !== an_of(d) || seg !== hx(nib_of(tc, d))) begin
                bad++;
                $display("FAIL latch_new_d%0d got=%h/%b want=%h/%b",
                         d, an, seg, an_of(d), hx(nib_of(tc, d)));
            end
        end
    endtask

    task automatic test_addr();
        logic [6:0] exp_seg [8];
        exp_seg[0] = 7'b0001110;
        exp_seg[1] = 7'b0001110;
        exp_seg[2] = 7'b0110000;
        for (int d = 3; d < 8; d++) exp_seg[d] = 7'b1000000;
        display_op = 3'b011;
        ram_display_addr = 10'h3FF;
        do_reset();
        for (int d = 0; d < 8; d++) begin
            next_digit();
            total++;
            if (an !== an_of(d) || seg !== exp_seg[d]) begin
                bad++;
                $display("FAIL addr_d%0d got=%h/%b want=%h/%b",
                         d, an, seg, an_of(d), exp_seg[d]);
            end
        end
    endtask

    task automatic test_blank();
        logic [31:0] rd;
        rd = 32'hA5C3_0F96;
        display_op = 3'b111;
        ram_data = rd;
        do_reset();
        for (int d = 0; d < 8; d++) begin
            next_digit();
            if (d == 4) display_op = 3'b010;
            total++;
            if (an !== 8'hFF || seg !== 7'h7F) begin
                bad++;
                $display("FAIL blank_d%0d got=%h/%b want=ff/1111111",
                         d, an, seg);
            end
        end
        for (int d = 0; d < 8; d++) begin
            next_digit();
            total++;
            if (an !== an_of(d) || seg !== hx(nib_of(rd, d))) begin
                bad++;
                $display("FAIL resume_d%0d got=%h/%b want=%h/%b",
                         d, an, seg, an_of(d), hx(nib_of(rd, d)));
            end
        end
    endtask

    task automatic test_async_reset();
        display_op = 3'b001;
        pc = 32'h89AB_CDEF;
        do_reset();
        for (int d = 0; d < 6; d++) next_digit();
        total++;
        if (an !== an_of(5)) begin
            bad++;
            $display("FAIL async_pre got=%h want=%h", an, an_of(5));
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (an !== 8'hFF || seg !== 7'h7F) begin
            bad++;
            $display("FAIL async_blank got=%h/%b want=ff/1111111", an, seg);
        end
        pc = 32'h0123_4567;
        @(negedge clk);
        rst_n = 1'b1;
        next_digit();
        total++;
        if (an !== 8'hFE || seg !== 7'b1111000) begin
            bad++;
            $display("FAIL async_restart got=%h/%b want=fe/1111000", an, seg);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        display_op = 3'b000;
        ram_display_addr = 10'h0;
        reg_out = 32'h0;
        pc = 32'h0;
        ram_data = 32'h0;
        total_cycles = 32'h0;
        jump_cycles = 32'h0;
        branch_cycles = 32'h0;
        test_reset();
        test_hex();
        test_frame_latch();
        test_addr();
        test_blank();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
